ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- Pipeline stage directly downstream of the ALU.
- Registers the ALU result and one-hot flags into a 2-entry skid buffer with valid/ready handshakes on both sides.
- Holds the architectural NZCV flag register, evaluates each instruction's condition code against it, and gates the register-file write enable.
- Tags divide/modulus-by-zero as an exception so writeback can drop the result.

Parameters:
- N, 8, data width; must match the ALU.
- RW, 4, register-index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream holds a valid ALU result.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  N  ALU result.
- in_flags  in  4  ALU flags, one-hot {N,Z,C,V}, or 0.
- in_ctrl  in  4  ALU opcode (0100 = mod, 1000 = div).
- in_b_zero  in  1  ALU operand b == 0.
- in_rd  in  RW  destination register.
- in_we  in  1  instruction writes rd.
- in_setf  in  1  instruction updates the flag register.
- in_cond  in  3  condition code.
- flush  in  1  discard all buffered and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head.
- out_result  out  N  head result.
- out_rd  out  RW  head destination.
- out_we  out  1  head write enable (already condition- and exception-gated).
- out_exc  out  1  head raised divide-by-zero.
- flags_q  out  4  architectural flag register {N,Z,C,V}.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state EMPTY; both entries cleared; flags_q = 0000.
  - out_valid = 0, out_we = 0, out_exc = 0, out_result = 0, out_rd = 0.
  - in_ready = 0 while rst_n = 0.
  - Reset has priority over every other input, including mid-operation with the buffer full.
- Buffer states:
  - EMPTY, ONE, TWO.
  - in_ready = (state != TWO), registered.
  - out_valid = (state != EMPTY).
  - Outputs always present the head entry, which is the oldest.
- Accept and pop rules:
  - Accept = in_valid & in_ready & ~flush.
  - Pop = out_valid & out_ready.
  - EMPTY: accept -> ONE.
  - ONE: accept & ~pop -> TWO; pop & ~accept -> EMPTY; accept & pop -> ONE, new entry becomes head.
  - TWO: pop -> ONE, second entry becomes head. No accept is possible.
  - Latency is 1 cycle: an entry accepted at edge k is visible at the head after edge k if the buffer was empty or popped on that edge.
  - Throughput is 1 per cycle with out_ready held high.
- Condition evaluation:
  - Evaluated at accept time against flags_q before that edge.
  - 000 AL true; 001 EQ Z; 010 NE !Z; 011 LT N; 100 GE !N; 101 CS C; 110 VS V; 111 NV false.
- Exception:
  - exc = (in_ctrl == 0100 or 1000) & in_b_zero & cond_true.
- Stored entry fields:
  - we = in_we & cond_true & ~exc.
  - result and rd stored as given.
- Flag register update:
  - flags_q <= in_flags on accept when in_setf & cond_true & ~exc.
  - Otherwise flags_q holds.
  - Back-to-back instructions therefore see the previous instruction's flags with no bubble.
- flush:
  - Next state EMPTY; out_valid = 0 the following cycle.
  - The input in the flush cycle is dropped and does not update flags.
  - flags_q keeps already-committed values.
  - flush with out_ready: the pop is irrelevant, the buffer still goes EMPTY.
- Invariants:
  - Entries never reorder, duplicate or drop, except under flush or reset.
  - While out_valid & ~out_ready, the head outputs are held stable.

Decomposition:
- Shared package holds:
  - ALU opcode constants (ALU_ADD .. ALU_SHR, including ALU_MOD = 4'b0100 and ALU_DIV = 4'b1000).
  - Flag bit positions FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - cond_e enum of the 8 condition codes.
  - Packed struct wb_entry_t {result, rd, we, exc}.
- Natural sub-module: cond_eval, a pure combinational function of (cond, flags_q) -> cond_true.
- The skid buffer stays inline.

Test Plan:
- Reset: rst_n = 0 for 2 cycles with the buffer full (state TWO) -> out_valid = 0, flags_q = 0000, in_ready = 0; after release in_ready = 1.
- Streaming: 4 entries, results 0x11, 0x22, 0x33, 0x44, cond AL, out_ready = 1 -> each appears 1 cycle after accept, in order, in_ready stays 1.
- Backpressure: out_ready = 0, push 0xA0 and 0xA1 -> in_ready = 0 after 2 accepts, head holds 0xA0 stable; raise out_ready -> 0xA0 then 0xA1, no loss.
- Flag forwarding:
  - First instruction: SUB with setf = 1, in_flags = 0100 -> flags_q = 0100.
  - Next cycle, EQ, we = 1 -> out_we = 1.
  - Following cycle, NE, we = 1 -> out_we = 0, flags_q unchanged.
- Divide-by-zero: in_ctrl = 1000, in_b_zero = 1, we = 1, setf = 1, in_flags = 0100 -> out_exc = 1, out_we = 0, flags_q unchanged. Same with cond NV -> out_exc = 0.
- Flush: buffer state TWO, assert flush while in_valid = 1 with setf = 1 -> next cycle out_valid = 0, state EMPTY, flags_q unchanged; the next accepted entry appears normally.

Source files
------------

// File: rtl/ex_wb_stage_pkg.sv
// Shared types and constants for the EX->WB stage: ALU opcodes, flag layout,
// condition codes and the buffered writeback entry.
package ex_wb_stage_pkg;

  localparam int WB_N  = 8;
  localparam int WB_RW = 4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MOD = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_NOT = 4'b0110;
  localparam logic [3:0] ALU_SHL = 4'b0111;
  localparam logic [3:0] ALU_DIV = 4'b1000;
  localparam logic [3:0] ALU_SHR = 4'b1001;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_CS = 3'b101,
    COND_VS = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [WB_N-1:0]  result;
    logic [WB_RW-1:0] rd;
    logic             we;
    logic             exc;
  } wb_entry_t;

  function automatic logic is_divmod(input logic [3:0] ctrl);
    return (ctrl == ALU_MOD) || (ctrl == ALU_DIV);
  endfunction

endpackage

// File: rtl/ex_wb_stage_cond_eval.sv
// Condition-code evaluation against the architectural NZCV register.
import ex_wb_stage_pkg::*;

module ex_wb_stage_cond_eval (
  input  logic [2:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_true_o
);

  always_comb begin
    cond_true_o = 1'b0;
    case (cond_e'(cond_i))
      COND_AL: cond_true_o = 1'b1;
      COND_EQ: cond_true_o = flags_i[FLAG_Z];
      COND_NE: cond_true_o = ~flags_i[FLAG_Z];
      COND_LT: cond_true_o = flags_i[FLAG_N];
      COND_GE: cond_true_o = ~flags_i[FLAG_N];
      COND_CS: cond_true_o = flags_i[FLAG_C];
      COND_VS: cond_true_o = flags_i[FLAG_V];
      COND_NV: cond_true_o = 1'b0;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_wb_stage.sv
// Post-ALU stage: 2-entry skid buffer toward writeback, NZCV flag register,
// condition gating of register writes and divide/modulus-by-zero tagging.
import ex_wb_stage_pkg::*;

module ex_wb_stage #(
  parameter int N  = WB_N,
  parameter int RW = WB_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_result,
  input  logic [3:0]    in_flags,
  input  logic [3:0]    in_ctrl,
  input  logic          in_b_zero,
  input  logic [RW-1:0] in_rd,
  input  logic          in_we,
  input  logic          in_setf,
  input  logic [2:0]    in_cond,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_we,
  output logic          out_exc,
  output logic [3:0]    flags_q
);

  buf_state_e state_q, state_d;
  wb_entry_t  head_q, head_d, tail_q, tail_d;
  wb_entry_t  new_entry;
  logic [3:0] flags_d;
  logic       in_ready_q;
  logic       cond_true, exc, accept, pop;

  ex_wb_stage_cond_eval u_cond (
    .cond_i      (in_cond),
    .flags_i     (flags_q),
    .cond_true_o (cond_true)
  );

  // Condition and exception are resolved against flags before this edge,
  // so the next instruction sees this one's flags with no bubble.
  assign exc    = is_divmod(in_ctrl) & in_b_zero & cond_true;
  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = out_valid & out_ready;

  always_comb begin
    new_entry        = '0;
    new_entry.result = in_result;
    new_entry.rd     = in_rd;
    new_entry.we     = in_we & cond_true & ~exc;
    new_entry.exc    = exc;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    flags_d = flags_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          tail_d  = new_entry;
          state_d = ST_TWO;
        end else if (pop && !accept) begin
          state_d = ST_EMPTY;
        end else if (accept && pop) begin
          head_d  = new_entry;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (accept && in_setf && cond_true && !exc) flags_d = in_flags;
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      flags_q    <= 4'b0000;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      flags_q    <= flags_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_we     = head_q.we;
  assign out_exc    = head_q.exc;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage with hand-computed expectations.
module tb_ex_wb_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in_result;
  logic [3:0] in_flags, in_ctrl;
  logic       in_b_zero;
  logic [3:0] in_rd;
  logic       in_we, in_setf;
  logic [2:0] in_cond;
  logic       flush;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [3:0] out_rd;
  logic       out_we, out_exc;
  logic [3:0] flags_q;

  int n_chk = 0;
  int n_err = 0;

  ex_wb_stage #(.N(8), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_ctrl(in_ctrl),
    .in_b_zero(in_b_zero), .in_rd(in_rd), .in_we(in_we),
    .in_setf(in_setf), .in_cond(in_cond), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd),
    .out_we(out_we), .out_exc(out_exc), .flags_q(flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] res, input logic [3:0] ctrl,
                       input logic bz, input logic we, input logic setf,
                       input logic [3:0] fl, input logic [2:0] cond);
    in_valid  = v;
    in_result = res;
    in_ctrl   = ctrl;
    in_b_zero = bz;
    in_we     = we;
    in_setf   = setf;
    in_flags  = fl;
    in_cond   = cond;
    in_rd     = res[3:0];
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0);
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // fill to TWO with a flag update, then reset while full
    drive(1'b1, 8'h55, 4'h0, 1'b0, 1'b1, 1'b1, 4'b0010, 3'd0);
    step();
    drive(1'b1, 8'h66, 4'h0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0);
    step();
    in_valid = 1'b0;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(out_result), 32'h55);
    chk("full_flags", 32'(flags_q), 32'b0010);
    rst_n = 1'b0;
    step(); step();
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_flags", 32'(flags_q), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd0);
    chk("rst2_result", 32'(out_result), 32'd0);
    chk("rst2_we", 32'(out_we), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rel2_in_ready", 32'(in_ready), 32'd1);

    // streaming
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h11 * (i + 1)), 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0);
      step();
      chk("strm_valid", 32'(out_valid), 32'd1);
      chk("strm_result", 32'(out_result), 32'(8'h11 * (i + 1)));
      chk("strm_rd", 32'(out_rd), 32'(i + 1));
      chk("strm_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_drain", 32'(out_valid), 32'd0);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 8'hA0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0);
    step();
    drive(1'b1, 8'hA1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0);
    step();
    in_valid = 1'b0;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_result), 32'hA0);
    step();
    chk("bp_hold", 32'(out_result), 32'hA0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_second", 32'(out_result), 32'hA1);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // flag forwarding: SUB sets Z, EQ passes, NE fails (and must not set flags)
    drive(1'b1, 8'h01, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0100, 3'd0);
    step();
    chk("ff_flags", 32'(flags_q), 32'b0100);
    chk("ff_sub_we", 32'(out_we), 32'd1);
    drive(1'b1, 8'h02, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'b001);
    step();
    chk("ff_eq_we", 32'(out_we), 32'd1);
    drive(1'b1, 8'h03, 4'h0, 1'b0, 1'b1, 1'b1, 4'b1000, 3'b010);
    step();
    chk("ff_ne_we", 32'(out_we), 32'd0);
    chk("ff_ne_flags", 32'(flags_q), 32'b0100);

    // divide / modulus by zero
    drive(1'b1, 8'h04, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0001, 3'd0);
    step();
    chk("dz_exc", 32'(out_exc), 32'd1);
    chk("dz_we", 32'(out_we), 32'd0);
    chk("dz_flags", 32'(flags_q), 32'b0100);
    drive(1'b1, 8'h05, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0001, 3'b111);
    step();
    chk("dz_nv_exc", 32'(out_exc), 32'd0);
    chk("dz_nv_we", 32'(out_we), 32'd0);
    drive(1'b1, 8'h06, 4'b0100, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0);
    step();
    chk("mz_exc", 32'(out_exc), 32'd1);
    drive(1'b1, 8'h07, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b0010, 3'd0);
    step();
    chk("div_ok_exc", 32'(out_exc), 32'd0);
    chk("div_ok_we", 32'(out_we), 32'd1);
    chk("div_ok_flags", 32'(flags_q), 32'b0010);

    // flush from TWO with out_ready high and a flag-setting input
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    drive(1'b1, 8'hB0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0);
    step();
    drive(1'b1, 8'hB1, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0);
    step();
    chk("fl_full", 32'(in_ready), 32'd0);
    drive(1'b1, 8'hB2, 4'h0, 1'b0, 1'b1, 1'b1, 4'b1000, 3'd0);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_flags", 32'(flags_q), 32'b0010);
    // flush from ONE while a flag-setting input is offered and accept-able
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 8'hB3, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0);
    step();
    drive(1'b1, 8'hB4, 4'h0, 1'b0, 1'b1, 1'b1, 4'b1000, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl1_valid", 32'(out_valid), 32'd0);
    chk("fl1_flags", 32'(flags_q), 32'b0010);
    out_ready = 1'b1;
    drive(1'b1, 8'hC3, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0);
    step();
    chk("post_fl_valid", 32'(out_valid), 32'd1);
    chk("post_fl_result", 32'(out_result), 32'hC3);
    chk("post_fl_we", 32'(out_we), 32'd1);
    in_valid = 1'b0;
    step();
    chk("post_fl_drain", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
